// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the MEM stage: load/store funct3 values and FSM states.
// Latency: none (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

    // funct3 encodings for loads and stores.
    // Stores use only the B/H/W values.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Memory access FSM.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store lane/strobe generation and load extraction with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are used.
// Ports: funct3_i/addr_lo_i select size and lane; rs2_i is store data and rdata_i the read word;
//        wdata_o/wstrb_o are the store lanes and load_data_o the extended load result.
module mem_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store lanes: data is replicated so the strobe alone picks the lane.
    always_comb begin
        wdata_o = rs2_i;
        wstrb_o = 4'b1111;
        case (funct3_i)
            F3_B: begin
                wdata_o = {4{rs2_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            F3_H: begin
                wdata_o = {2{rs2_i[15:0]}};
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_o = rs2_i;
                wstrb_o = 4'b1111;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
    end

    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: EX/MEM register, data-memory access FSM with timeout, MEM/WB register, EX forwarding source.
// Latency: ALU op reaches WB two edges after leaving EX; a load adds one cycle per dmem_ready-low cycle.
// Backpressure: stall holds EX/MEM and upstream while an access waits; aborted after MAX_WAIT cycles.
// Ports: ex_* from EX; stall to upstream; dmem_* memory port (req/ready handshake);
//        fwd_* forwarding source for EX; wb_* MEM/WB register; misalign_err/timeout_err pulse with dropped WB slot.
module mem_stage
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_res,
    input  logic [31:0] ex_reg1,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        fwd_we,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    // EX/MEM register
    logic        valid_q;
    logic [31:0] res_q;
    logic [31:0] rs2_q;
    logic [4:0]  rd_q;
    logic        reg_write_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [2:0]  funct3_q;

    // FSM
    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // MEM/WB register
    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        is_load, is_store, is_mem, legal, fault, mem_op;
    logic        abort;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

    // Access decode. A slot with both read and write set is treated as a load.
    assign is_load  = valid_q & mem_read_q;
    assign is_store = valid_q & mem_write_q & ~mem_read_q;
    assign is_mem   = is_load | is_store;

    always_comb begin
        legal = 1'b0;
        case (funct3_q)
            F3_B:         legal = 1'b1;
            F3_BU:        legal = is_load;
            F3_H:         legal = ~res_q[0];
            F3_HU:        legal = is_load & ~res_q[0];
            F3_W:         legal = (res_q[1:0] == 2'b00);
            default:      legal = 1'b0;
        endcase
    end

    assign fault  = is_mem & ~legal;
    assign mem_op = is_mem & legal;

    mem_align u_align (
        .funct3_i    (funct3_q),
        .addr_lo_i   (res_q[1:0]),
        .rs2_i       (rs2_q),
        .rdata_i     (dmem_rdata),
        .wdata_o     (st_wdata),
        .wstrb_o     (st_wstrb),
        .load_data_o (ld_data)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_op && !dmem_ready) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ready || cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs. The EX/MEM slot is held in WAIT, so mem_op stays true there.
    always_comb begin
        stall    = 1'b0;
        dmem_req = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_RUN: begin
                dmem_req = mem_op;
                stall    = mem_op & ~dmem_ready;
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                stall    = ~dmem_ready & (cnt_q != CNT_LAST);
                abort    = ~dmem_ready & (cnt_q == CNT_LAST);
            end
            default: ;
        endcase
    end

    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = {res_q[31:2], 2'b00};
    assign dmem_wdata = dmem_we ? st_wdata : 32'd0;
    assign dmem_wstrb = dmem_we ? st_wstrb : 4'd0;

    // EX/MEM register: held while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            res_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            funct3_q    <= '0;
        end else if (!stall) begin
            valid_q     <= ex_valid;
            res_q       <= ex_res;
            rs2_q       <= ex_reg1;
            rd_q        <= ex_rd;
            reg_write_q <= ex_reg_write;
            mem_read_q  <= ex_mem_read;
            mem_write_q <= ex_mem_write;
            funct3_q    <= ex_funct3;
        end
    end

    // MEM/WB next value: bubble while stalled, on fault, or on abort.
    always_comb begin
        wb_valid_d     = valid_q & ~stall & ~fault & ~abort;
        wb_reg_write_d = reg_write_q & wb_valid_d;
        wb_rd_d        = rd_q;
        wb_data_d      = is_load ? ld_data : res_q;
        misalign_d     = fault;
        timeout_d      = abort;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            misalign_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            misalign_q     <= misalign_d;
            timeout_q      <= timeout_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;

    // Loads are not forwardable from MEM; their data only exists at WB.
    assign fwd_we   = valid_q & reg_write_q & ~mem_read_q;
    assign fwd_rd   = rd_q;
    assign fwd_data = res_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_res;
    logic [31:0] ex_reg1;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_res       (ex_res),
        .ex_reg1      (ex_reg1),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .fwd_we       (fwd_we),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        ex_valid     = 1'b0;
        ex_res       = 32'd0;
        ex_reg1      = 32'd0;
        ex_rd        = 5'd0;
        ex_reg_write = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_funct3    = 3'd0;
    endtask

    task automatic drive_ex(input logic [31:0] res, input logic [31:0] rs2, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        ex_valid     = 1'b1;
        ex_res       = res;
        ex_reg1      = rs2;
        ex_rd        = rd;
        ex_reg_write = rw;
        ex_mem_read  = mr;
        ex_mem_write = mw;
        ex_funct3    = f3;
    endtask

    // Present one instruction for one edge; returns #1 after the following negedge,
    // with the instruction in EX/MEM and EX inputs idle.
    task automatic issue(input logic [31:0] res, input logic [31:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
        @(negedge clk);
        drive_ex(res, rs2, rd, rw, mr, mw, f3);
        @(negedge clk);
        drive_idle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({wb_valid, wb_reg_write, misalign_err, timeout_err, stall, dmem_req, fwd_we} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {wb_valid, wb_reg_write, misalign_err, timeout_err, stall, dmem_req, fwd_we});
        end
        n_checks++;
        if (wb_data !== 32'd0 || wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: wb_data=%h wb_rd=%0d expected 0/0", wb_data, wb_rd);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lw_zero_wait();
        int stall_seen;
        stall_seen = 0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        issue(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010);
        if (stall) stall_seen++;
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_wstrb !== 4'd0 || dmem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_req: req=%b addr=%h wstrb=%b we=%b expected 1/00000100/0000/0",
                     dmem_req, dmem_addr, dmem_wstrb, dmem_we);
        end
        n_checks++;
        if (fwd_we !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_fwd_we: got %b expected 0", fwd_we);
        end
        @(negedge clk);
        #1;
        if (stall) stall_seen++;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_wb: valid=%b data=%h rd=%0d rw=%b expected 1/deadbeef/5/1",
                     wb_valid, wb_data, wb_rd, wb_reg_write);
        end
        n_checks++;
        if (stall_seen !== 0) begin
            n_fail++;
            $display("FAIL lw_stall: stall seen %0d cycles expected 0", stall_seen);
        end
    endtask

    task automatic test_sb();
        dmem_ready = 1'b1;
        issue(32'h203, 32'h000000A5, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
            dmem_wstrb !== 4'b1000 || dmem_wdata !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL sb_req: req=%b we=%b addr=%h wstrb=%b wdata=%h expected 1/1/00000200/1000/a5a5a5a5",
                     dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_wb: valid=%b rw=%b merr=%b expected 1/0/0", wb_valid, wb_reg_write, misalign_err);
        end
    endtask

    task automatic test_load_extract();
        logic [2:0]  f3  [5];
        logic [31:0] adr [5];
        logic [31:0] exp [5];
        f3[0] = 3'b000; adr[0] = 32'h301; exp[0] = 32'h0000007F;
        f3[1] = 3'b000; adr[1] = 32'h302; exp[1] = 32'hFFFFFFFF;
        f3[2] = 3'b100; adr[2] = 32'h302; exp[2] = 32'h000000FF;
        f3[3] = 3'b001; adr[3] = 32'h302; exp[3] = 32'hFFFF80FF;
        f3[4] = 3'b101; adr[4] = 32'h300; exp[4] = 32'h00007F01;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80FF7F01;
        for (int i = 0; i < 5; i++) begin
            issue(adr[i], 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, f3[i]);
            @(negedge clk);
            #1;
            n_checks++;
            if (wb_valid !== 1'b1 || wb_data !== exp[i]) begin
                n_fail++;
                $display("FAIL load_extract[%0d]: valid=%b data=%h expected 1/%h", i, wb_valid, wb_data, exp[i]);
            end
        end
    endtask

    task automatic test_wait3();
        int stall_cnt;
        stall_cnt = 0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h12345678;
        issue(32'h40, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010);
        // A following ALU op waits in EX while the load is stuck.
        drive_ex(32'h999, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (i == 3) begin
                dmem_ready = 1'b1;
                #1;
            end
            if (stall) stall_cnt++;
            n_checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h40 || dmem_we !== 1'b0 || fwd_we !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h we=%b fwd_we=%b expected 1/00000040/0/0",
                         i, dmem_req, dmem_addr, dmem_we, fwd_we);
            end
            if (i == 1 || i == 2) begin
                n_checks++;
                if (wb_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_bubble[%0d]: wb_valid=%b expected 0", i, wb_valid);
                end
            end
        end
        n_checks++;
        if (stall_cnt !== 3) begin
            n_fail++;
            $display("FAIL wait_stall_cycles: got %0d expected 3", stall_cnt);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h12345678 || wb_rd !== 5'd9) begin
            n_fail++;
            $display("FAIL wait_wb: valid=%b data=%h rd=%0d expected 1/12345678/9", wb_valid, wb_data, wb_rd);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h999 || wb_rd !== 5'd4) begin
            n_fail++;
            $display("FAIL wait_next_alu: valid=%b data=%h rd=%0d expected 1/00000999/4", wb_valid, wb_data, wb_rd);
        end
    endtask

    task automatic test_misalign();
        dmem_ready = 1'b1;
        issue(32'h102, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010);
        n_checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_req: req=%b stall=%b expected 0/0", dmem_req, stall);
        end
        drive_ex(32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || misalign_err !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_wb: valid=%b merr=%b expected 0/1", wb_valid, misalign_err);
        end
        n_checks++;
        if (fwd_we !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'h55) begin
            n_fail++;
            $display("FAIL fwd_add: we=%b rd=%0d data=%h expected 1/3/00000055", fwd_we, fwd_rd, fwd_data);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd3 || misalign_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_next: valid=%b data=%h rd=%0d merr=%b expected 1/00000055/3/0",
                     wb_valid, wb_data, wb_rd, misalign_err);
        end
        // lhu at an odd address is also a fault.
        issue(32'h101, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b101);
        n_checks++;
        if (dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL lhu_odd_req: req=%b expected 0", dmem_req);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b0 || misalign_err !== 1'b1) begin
            n_fail++;
            $display("FAIL lhu_odd_wb: valid=%b merr=%b expected 0/1", wb_valid, misalign_err);
        end
    endtask

    task automatic test_timeout();
        int stall_cnt;
        stall_cnt = 0;
        dmem_ready = 1'b0;
        issue(32'h80, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (stall) stall_cnt++;
        end
        n_checks++;
        if (stall_cnt !== 3 || stall !== 1'b0 || dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_stall: cycles=%0d stall=%b req=%b expected 3/0/1", stall_cnt, stall, dmem_req);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (timeout_err !== 1'b1 || wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: terr=%b valid=%b req=%b expected 1/0/0", timeout_err, wb_valid, dmem_req);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_one_cycle: terr=%b expected 0", timeout_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        dmem_ready = 1'b0;
        issue(32'h84, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b010);
        @(negedge clk);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait_pre: stall=%b expected 1", stall);
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait_clear: req=%b stall=%b valid=%b terr=%b expected 0/0/0/0",
                     dmem_req, stall, wb_valid, timeout_err);
        end
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        issue(32'h88, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 3'b010);
        @(negedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL rst_wait_recover: valid=%b data=%h expected 1/0badf00d", wb_valid, wb_data);
        end
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_sb();
        test_load_extract();
        test_wait3();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
